// File: rtl/mcb_port_responder_pkg.sv
// Shared definitions for the MCB-style port responder.
// Holds the command opcodes, the responder state encoding and the packed
// layouts of the command and write-data FIFO entries.
package mcb_port_responder_pkg;

  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam logic [2:0] CMD_WRITE_PC = 3'b010;
  localparam logic [2:0] CMD_READ_PC  = 3'b011;
  localparam logic [2:0] CMD_REFRESH  = 3'b100;

  typedef enum logic [2:0] {
    ST_CAL     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_REFRESH = 3'd4
  } state_t;

  // Command FIFO entry, 37 bits: {instr, bl, addr}
  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [27:0] addr;
  } cmd_t;

  // Write FIFO entry, 36 bits: {mask, data}
  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_word_t;

  // Burst length field holds (words - 1).
  function automatic logic [6:0] burst_words(input logic [5:0] bl);
    return {1'b0, bl} + 7'd1;
  endfunction

endpackage

// File: rtl/mcb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_data    write strobe and data
//   i_pop             read strobe (ignored while empty)
//   o_data            head entry, reads 0 while empty
//   o_full, o_empty   occupancy flags
//   o_count           occupancy, 0..2**DEPTH_LOG2
// A full FIFO accepts a simultaneous push and pop; an empty FIFO only
// takes the push.
module mcb_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_COUNT);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Masking the head keeps the output at 0 after reset instead of stale RAM.
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Responder end of an MCB-style user port, backed by on-chip word memory.
// Ports:
//   clk, rst                      port clock, asynchronous active-high reset
//   calibration_done              high CAL_CYCLES cycles after reset release
//   cmd_*                         command strobe/fields and FIFO flags
//   wr_*                          write-data strobe, mask, data, flags, count,
//                                 underrun (level) and error (sticky)
//   rd_*                          read pop strobe, FWFT data, flags, count,
//                                 overflow and error (both sticky)
module mcb_port_responder
  import mcb_port_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int CAL_CYCLES     = 16,
  parameter int CMD_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        calibration_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [27:0] cmd_word_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int CAL_W     = $clog2(CAL_CYCLES + 1);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CAL_W-1:0]          r_cal_cnt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [6:0]                r_remaining;
  logic                      r_rd_vld;
  logic                      r_wr_error;
  logic                      r_rd_error;
  logic                      r_rd_overflow;

  logic                      w_cmd_en, w_wr_en, w_rd_en;
  logic                      w_cmd_pop, w_wr_pop, w_mem_re;
  cmd_t                      w_cmd_head;
  wr_word_t                  w_wr_head;
  logic [3:0][7:0]           w_mem_rdata;
  logic [CMD_DEPTH_LOG2:0]   w_unused_cmd_count;
  logic                      w_unused_addr;

  // Strobes are ignored entirely until calibration completes.
  assign calibration_done = (r_state != ST_CAL);
  assign w_cmd_en = cmd_en && calibration_done;
  assign w_wr_en  = wr_en  && calibration_done;
  assign w_rd_en  = rd_en  && calibration_done;

  assign wr_underrun = (r_state == ST_WRITE) && wr_empty;
  assign wr_error    = r_wr_error;
  assign rd_error    = r_rd_error;
  assign rd_overflow = r_rd_overflow;
  assign w_unused_addr = ^w_cmd_head.addr[27:MEM_ADDR_WIDTH];

  mcb_sync_fifo #(.WIDTH(37), .DEPTH_LOG2(CMD_DEPTH_LOG2)) u_cmd_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_cmd_en), .i_data({cmd_instr, cmd_bl, cmd_word_addr}), .i_pop(w_cmd_pop),
    .o_data(w_cmd_head), .o_full(cmd_full), .o_empty(cmd_empty), .o_count(w_unused_cmd_count)
  );

  mcb_sync_fifo #(.WIDTH(36), .DEPTH_LOG2(6)) u_wr_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_wr_en), .i_data({wr_mask, wr_data}), .i_pop(w_wr_pop),
    .o_data(w_wr_head), .o_full(wr_full), .o_empty(wr_empty), .o_count(wr_count)
  );

  // The registered memory word lands here one cycle after its read.
  mcb_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(6)) u_rd_fifo (
    .clk(clk), .rst(rst),
    .i_push(r_rd_vld), .i_data(w_mem_rdata), .i_pop(w_rd_en),
    .o_data(rd_data), .o_full(rd_full), .o_empty(rd_empty), .o_count(rd_count)
  );

  // One byte-wide RAM per lane so the write mask maps onto lane enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_lane [MEM_DEPTH];
    logic [7:0] r_lane_q;
    always_ff @(posedge clk) begin
      if (w_wr_pop && !w_wr_head.mask[gi]) r_lane[r_addr] <= w_wr_head.data[gi*8 +: 8];
      if (w_mem_re) r_lane_q <= r_lane[r_addr];
    end
    assign w_mem_rdata[gi] = r_lane_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_CAL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_pop    = 1'b0;
    w_wr_pop     = 1'b0;
    w_mem_re     = 1'b0;
    case (r_state)
      ST_CAL: begin
        if (r_cal_cnt == CAL_LAST) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!cmd_empty) begin
          w_cmd_pop = 1'b1;
          case (w_cmd_head.instr)
            CMD_WRITE, CMD_WRITE_PC: w_state_next = ST_WRITE;
            CMD_READ, CMD_READ_PC:   w_state_next = ST_READ;
            CMD_REFRESH:             w_state_next = ST_REFRESH;
            default:                 w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: begin
        if (!wr_empty) begin
          w_wr_pop = 1'b1;
          if (r_remaining == 7'd1) w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        // With nothing left to issue, this cycle pushes the final word.
        if (r_remaining != 7'd0) w_mem_re = 1'b1;
        else                     w_state_next = ST_IDLE;
      end
      ST_REFRESH: w_state_next = ST_IDLE;
      default:    w_state_next = ST_CAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cal_cnt     <= '0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_rd_vld      <= 1'b0;
      r_wr_error    <= 1'b0;
      r_rd_error    <= 1'b0;
      r_rd_overflow <= 1'b0;
    end else begin
      if (r_state == ST_CAL) r_cal_cnt <= r_cal_cnt + 1'b1;
      if (w_cmd_pop) begin
        r_addr      <= w_cmd_head.addr[MEM_ADDR_WIDTH-1:0];
        r_remaining <= burst_words(w_cmd_head.bl);
      end else if (w_wr_pop || w_mem_re) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 7'd1;
      end
      r_rd_vld <= w_mem_re;
      // A full FIFO still takes a word when a pop happens in the same cycle.
      if (w_wr_en && wr_full && !w_wr_pop) r_wr_error <= 1'b1;
      if (w_rd_en && rd_empty)             r_rd_error <= 1'b1;
      if (r_rd_vld && rd_full && !w_rd_en) r_rd_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcb_port_responder.sv
module tb_mcb_port_responder;
  import mcb_port_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic        calibration_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [27:0] cmd_word_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun, wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow, rd_error;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_word;

  mcb_port_responder dut (
    .clk(clk), .rst(rst), .calibration_done(calibration_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_word_addr(cmd_word_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
    .wr_count(wr_count), .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && calibration_done && rd_en && !rd_empty) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no word", rd_data);
      end else begin
        exp_word = sb.pop_front();
        check("rd_data", rd_data, exp_word);
      end
    end
  end

  // {cal, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full,
  //  wr_underrun, wr_error, rd_overflow, rd_error}
  function automatic logic [31:0] flags();
    return {21'd0, calibration_done, cmd_empty, cmd_full, wr_empty, wr_full,
            rd_empty, rd_full, wr_underrun, wr_error, rd_overflow, rd_error};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [27:0] addr);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_word_addr = addr;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
    wr_en = 1'b1; wr_data = data; wr_mask = mask;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_rd_count(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rd_count != 7'(n) && k < budget) begin
      tick();
      k++;
    end
    check(name, {25'd0, rd_count}, n);
  endtask

  task automatic wait_wr_empty(input int budget, input string name);
    int k;
    k = 0;
    while (!wr_empty && k < budget) begin
      tick();
      k++;
    end
    check(name, {31'd0, wr_empty}, 1);
  endtask

  task automatic read_back(input logic [2:0] instr, input logic [5:0] bl, input logic [27:0] addr);
    do_cmd(instr, bl, addr);
    wait_rd_count(int'(bl) + 1, 300, "rb_count");
    pop_n(int'(bl) + 1);
  endtask

  initial begin
    rst = 1'b1; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_word_addr = '0;
    wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", flags(), 32'h2A0);
    check("reset_counts", {18'd0, wr_count, rd_count}, 0);
    check("reset_rd_data", rd_data, 0);

    // 1: calibration delay; strobes before it are ignored
    rst = 1'b0;
    cmd_en = 1'b1; cmd_instr = CMD_WRITE; wr_en = 1'b1; wr_data = 32'h5555; rd_en = 1'b1;
    tick();
    cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (14) tick();
    check("cal_done_cycle15", {31'd0, calibration_done}, 0);
    tick();
    check("cal_done_cycle16", {31'd0, calibration_done}, 1);
    check("precal_wr_count", {25'd0, wr_count}, 0);
    check("precal_cmd_empty", {31'd0, cmd_empty}, 1);
    check("precal_rd_error", {31'd0, rd_error}, 0);

    // 2: 64-word write-PC then read-PC
    wr_en = 1'b1; wr_mask = 4'h0;
    for (int i = 0; i < 64; i++) begin
      wr_data = 32'h1000 + i;
      tick();
    end
    wr_en = 1'b0;
    check("t2_wr_count", {25'd0, wr_count}, 64);
    check("t2_wr_full", {31'd0, wr_full}, 1);
    do_cmd(CMD_WRITE_PC, 6'd63, 28'h40);
    wait_wr_empty(120, "t2_wr_drain");
    repeat (3) tick();
    for (int i = 0; i < 64; i++) sb.push_back(32'h1000 + i);
    do_cmd(CMD_READ_PC, 6'd63, 28'h40);
    wait_rd_count(64, 200, "t2_rd_count");
    check("t2_rd_full", {31'd0, rd_full}, 1);
    pop_n(64);
    check("t2_rd_empty", {31'd0, rd_empty}, 1);
    check("t2_wr_empty", {31'd0, wr_empty}, 1);

    // 3: write underrun
    push_wr(32'hA000_0000, 4'h0);
    do_cmd(CMD_WRITE, 6'd3, 28'h80);
    repeat (3) tick();
    check("t3_underrun_set", {31'd0, wr_underrun}, 1);
    wr_en = 1'b1; wr_data = 32'hA000_0001;
    tick();
    check("t3_underrun_fall", {31'd0, wr_underrun}, 0);
    wr_data = 32'hA000_0002;
    tick();
    wr_data = 32'hA000_0003;
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    check("t3_underrun_done", {31'd0, wr_underrun}, 0);
    check("t3_wr_empty", {31'd0, wr_empty}, 1);
    for (int i = 0; i < 4; i++) sb.push_back(32'hA000_0000 + i);
    read_back(CMD_READ, 6'd3, 28'h80);

    // 4: byte masks (mask bit n protects byte n) and read latency
    push_wr(32'hFFFF_FFFF, 4'h0);
    push_wr(32'hFFFF_FFFF, 4'h0);
    do_cmd(CMD_WRITE, 6'd1, 28'h10);
    push_wr(32'h0000_0000, 4'b0101);
    do_cmd(CMD_WRITE, 6'd0, 28'h10);
    push_wr(32'h0000_0000, 4'b1010);
    do_cmd(CMD_WRITE, 6'd0, 28'h11);
    repeat (8) tick();
    sb.push_back(32'h00FF_00FF);
    sb.push_back(32'hFF00_FF00);
    do_cmd(CMD_READ, 6'd1, 28'h10);
    repeat (2) tick();
    check("t4_rd_empty_T3", {31'd0, rd_empty}, 1);
    tick();
    check("t4_rd_empty_T4", {31'd0, rd_empty}, 0);
    wait_rd_count(2, 20, "t4_rd_count");
    pop_n(2);

    // 5: overflow, rd_error, wr_error
    for (int i = 0; i < 64; i++) sb.push_back(32'h1000 + i);
    do_cmd(CMD_READ, 6'd63, 28'h40);
    do_cmd(CMD_READ, 6'd63, 28'h40);
    repeat (150) tick();
    check("t5_rd_overflow", {31'd0, rd_overflow}, 1);
    check("t5_rd_count", {25'd0, rd_count}, 64);
    pop_n(64);
    check("t5_rd_error_before", {31'd0, rd_error}, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_rd_error", {31'd0, rd_error}, 1);
    check("t5_rd_count_empty", {25'd0, rd_count}, 0);
    wr_en = 1'b1; wr_mask = 4'h0;
    for (int i = 0; i < 64; i++) begin
      wr_data = 32'h2000 + i;
      tick();
    end
    check("t5_wr_full", {31'd0, wr_full}, 1);
    check("t5_wr_error_before", {31'd0, wr_error}, 0);
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    check("t5_wr_error", {31'd0, wr_error}, 1);
    check("t5_wr_count", {25'd0, wr_count}, 64);
    do_cmd(CMD_WRITE_PC, 6'd63, 28'h100);
    wait_wr_empty(120, "t5_wr_drain");
    repeat (3) tick();

    // 6: address wrap, upper bits ignored, reset mid-burst
    for (int i = 0; i < 4; i++) push_wr(32'h6000_0000 + i, 4'h0);
    do_cmd(CMD_WRITE, 6'd3, 28'hABC_03FE);
    repeat (10) tick();
    sb.push_back(32'h6000_0002);
    sb.push_back(32'h6000_0003);
    read_back(CMD_READ, 6'd1, 28'h000);
    for (int i = 0; i < 4; i++) sb.push_back(32'h6000_0000 + i);
    read_back(CMD_READ_PC, 6'd3, 28'h3FE);
    do_cmd(CMD_READ, 6'd63, 28'h40);
    repeat (10) tick();
    check("t6_mid_burst", {31'd0, rd_empty}, 0);
    rst = 1'b1;
    #2;
    check("t6_reset_flags", flags(), 32'h2A0);
    check("t6_reset_counts", {18'd0, wr_count, rd_count}, 0);
    check("t6_reset_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    repeat (16) tick();
    check("t6_recal", {31'd0, calibration_done}, 1);
    repeat (70) tick();
    check("t6_burst_aborted", {25'd0, rd_count}, 0);
    sb.push_back(32'h6000_0002);
    read_back(CMD_READ, 6'd0, 28'h000);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
